// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with per-entry saturating direction
// counters, a fetch->decode prediction register and decode-stage resolution.
// Optional macro BP_STATS_EN builds the resolved-branch / mispredict counters;
// without it both statistics ports read 0.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int PC_W    = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PC_W-1:0] pc_f_i,
  output logic            pred_taken_f_o,
  output logic [PC_W-1:0] pred_target_f_o,
  input  logic            stall_d_i,
  input  logic            flush_d_i,
  input  logic            resolve_d_i,
  input  logic [PC_W-1:0] pc_d_i,
  input  logic            taken_d_i,
  input  logic [PC_W-1:0] target_d_i,
  output logic            mispredict_d_o,
  output logic [PC_W-1:0] redirect_pc_d_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispredict_cnt_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));

  logic [ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q [ENTRIES];

  logic             pred_taken_d;
  logic [PC_W-1:0]  pred_target_d;

  logic [IDX_W-1:0] idx_f, idx_d;
  logic [TAG_W-1:0] tag_f, tag_d;
  logic             hit_f, hit_d, update;
  logic [PC_W-1:0]  pc_f_seq, pc_d_seq;

  assign idx_f    = pc_f_i[IDX_W+1:2];
  assign tag_f    = pc_f_i[PC_W-1:IDX_W+2];
  assign idx_d    = pc_d_i[IDX_W+1:2];
  assign tag_d    = pc_d_i[PC_W-1:IDX_W+2];
  assign pc_f_seq = pc_f_i + PC_W'(4);
  assign pc_d_seq = pc_d_i + PC_W'(4);

  // Fetch lookup is suppressed during reset so the table's pre-reset
  // contents never leak out while it is being cleared.
  assign hit_f           = !rst_i && vld_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_taken_f_o  = hit_f && cnt_q[idx_f][CNT_W-1];
  assign pred_target_f_o = pred_taken_f_o ? tgt_q[idx_f] : pc_f_seq;

  assign hit_d  = vld_q[idx_d] && (tag_q[idx_d] == tag_d);
  assign update = resolve_d_i && !stall_d_i;

  // Resolution: a real branch compares against the carried prediction; a
  // non-branch that was predicted taken must fall back to pc+4.
  always_comb begin
    mispredict_d_o  = 1'b0;
    redirect_pc_d_o = taken_d_i ? target_d_i : pc_d_seq;
    if (update) begin
      mispredict_d_o = (taken_d_i != pred_taken_d) ||
                       (taken_d_i && (target_d_i != pred_target_d));
    end else if (!resolve_d_i && pred_taken_d && !stall_d_i && !rst_i) begin
      mispredict_d_o  = 1'b1;
      redirect_pc_d_o = pc_d_seq;
    end
  end

  // F->D prediction register: flush beats stall.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_d_i) begin
      pred_taken_d  <= 1'b0;
      pred_target_d <= '0;
    end else if (!stall_d_i) begin
      pred_taken_d  <= pred_taken_f_o;
      pred_target_d <= pred_target_f_o;
    end
  end

  // Valid bits and direction counters; reset discards any in-flight update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= '0;
    end else if (update) begin
      if (hit_d) begin
        if (taken_d_i && cnt_q[idx_d] != CNT_MAX)
          cnt_q[idx_d] <= cnt_q[idx_d] + CNT_W'(1);
        else if (!taken_d_i && cnt_q[idx_d] != '0)
          cnt_q[idx_d] <= cnt_q[idx_d] - CNT_W'(1);
      end else if (taken_d_i) begin
        vld_q[idx_d] <= 1'b1;
        cnt_q[idx_d] <= CNT_WT;
      end
    end
  end

  // Tag/target payload; only meaningful behind a valid bit, so no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && update && taken_d_i) begin
      tgt_q[idx_d] <= target_d_i;
      if (!hit_d) tag_q[idx_d] <= tag_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  // Saturating statistics counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (update && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict_d_o && !stall_d_i && mp_cnt_q != '1) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign branch_cnt_o     = rst_i ? '0 : br_cnt_q;
  assign mispredict_cnt_o = rst_i ? '0 : mp_cnt_q;
`else
  assign branch_cnt_o     = '0;
  assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default parameters).
module tb_branch_predictor;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_f_i, pc_d_i, target_d_i;
  logic        stall_d_i, flush_d_i, resolve_d_i, taken_d_i;
  logic        pred_taken_f_o, mispredict_d_o;
  logic [31:0] pred_target_f_o, redirect_pc_d_o, branch_cnt_o, mispredict_cnt_o;

`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  branch_predictor dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_f_i(pc_f_i),
    .pred_taken_f_o(pred_taken_f_o), .pred_target_f_o(pred_target_f_o),
    .stall_d_i(stall_d_i), .flush_d_i(flush_d_i), .resolve_d_i(resolve_d_i),
    .pc_d_i(pc_d_i), .taken_d_i(taken_d_i), .target_d_i(target_d_i),
    .mispredict_d_o(mispredict_d_o), .redirect_pc_d_o(redirect_pc_d_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_stats(input string tag, input int br, input int mp);
    chk({tag, "_br"}, branch_cnt_o, STATS ? 32'(br) : 32'd0);
    chk({tag, "_mp"}, mispredict_cnt_o, STATS ? 32'(mp) : 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; stall_d_i = 0; flush_d_i = 0; resolve_d_i = 0; taken_d_i = 0;
    pc_d_i = '0; target_d_i = '0; pc_f_i = 32'h0040_0010;
    cyc(); cyc();
    chk("rst_pt", 32'(pred_taken_f_o), 0);
    chk("rst_tgt", pred_target_f_o, 32'h0040_0014);
    chk("rst_mis", 32'(mispredict_d_o), 0);
    chk_stats("rst", 0, 0);

    rst_i = 1'b0; cyc();                               // T1: cold lookup
    chk("cold_pt", 32'(pred_taken_f_o), 0);
    chk("cold_tgt", pred_target_f_o, 32'h0040_0014);

    // T2: taken branch misses -> mispredict, allocate
    pc_d_i = 32'h0040_0010; resolve_d_i = 1; taken_d_i = 1; target_d_i = 32'h0040_0100; #1;
    chk("alloc_mis", 32'(mispredict_d_o), 1);
    chk("alloc_redir", redirect_pc_d_o, 32'h0040_0100);
    chk("same_cyc_old", 32'(pred_taken_f_o), 0);
    cyc();

    resolve_d_i = 0; #1;                               // T3: now hits weakly taken
    chk("hit_pt", 32'(pred_taken_f_o), 1);
    chk("hit_tgt", pred_target_f_o, 32'h0040_0100);
    chk("hit_nomis", 32'(mispredict_d_o), 0);
    cyc();

    resolve_d_i = 1;                                   // T4-6: three correct taken
    for (int i = 0; i < 3; i++) begin
      #1 chk("taken_ok", 32'(mispredict_d_o), 0);
      cyc();
    end

    taken_d_i = 0; #1;                                 // T7: counter 3 -> 2
    chk("nt1_mis", 32'(mispredict_d_o), 1);
    chk("nt1_redir", redirect_pc_d_o, 32'h0040_0014);
    cyc();
    #1;                                                // T8: counter 2 -> 1
    chk("nt2_pt", 32'(pred_taken_f_o), 1);
    chk("nt2_mis", 32'(mispredict_d_o), 1);
    cyc();

    resolve_d_i = 0; pc_d_i = 32'h0040_0020; #1;       // T9: saturation proof + alias
    chk("sat_pt", 32'(pred_taken_f_o), 0);
    chk("sat_tgt", pred_target_f_o, 32'h0040_0014);
    chk("nonbr_mis", 32'(mispredict_d_o), 1);
    chk("nonbr_redir", redirect_pc_d_o, 32'h0040_0024);
    cyc();

    // stalled taken branch, counter at 1
    resolve_d_i = 1; taken_d_i = 1; pc_d_i = 32'h0040_0010; target_d_i = 32'h0040_0100;
    stall_d_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_mis", 32'(mispredict_d_o), 0);
      chk_stats("stall", 6, 4);
      cyc();
    end
    stall_d_i = 0; #1;                                 // release: one update 1 -> 2
    chk("rel_mis", 32'(mispredict_d_o), 1);
    chk("rel_redir", redirect_pc_d_o, 32'h0040_0100);
    cyc();
    taken_d_i = 0; pc_f_i = 32'h0040_0200; #1;         // 2 -> 1 (3 -> 2 if stalled updates leaked)
    chk("post_nt_mis", 32'(mispredict_d_o), 0);
    cyc();
    resolve_d_i = 0; pc_f_i = 32'h0040_0010; #1;
    chk("once_pt", 32'(pred_taken_f_o), 0);
    chk("once_mis", 32'(mispredict_d_o), 0);
    cyc();

    pc_f_i = 32'h0040_0110; #1;                        // alias index 4, other tag
    chk("alias_pt", 32'(pred_taken_f_o), 0);
    cyc();
    resolve_d_i = 1; taken_d_i = 1; pc_d_i = 32'h0040_0110; target_d_i = 32'h0040_0500;
    pc_f_i = 32'h0040_0200; #1;
    chk("evict_mis", 32'(mispredict_d_o), 1);
    chk("evict_redir", redirect_pc_d_o, 32'h0040_0500);
    cyc();
    resolve_d_i = 0; pc_f_i = 32'h0040_0110; flush_d_i = 1; #1;
    chk("new_pt", 32'(pred_taken_f_o), 1);
    chk("new_tgt", pred_target_f_o, 32'h0040_0500);
    cyc();
    flush_d_i = 0; pc_f_i = 32'h0040_0010; #1;
    chk("old_gone_pt", 32'(pred_taken_f_o), 0);
    chk("flush_mis", 32'(mispredict_d_o), 0);
    cyc();

    pc_f_i = 32'h0040_0110; #1;                        // capture taken into F->D
    chk("cap_mis", 32'(mispredict_d_o), 0);
    cyc();
    stall_d_i = 1; flush_d_i = 1; #1;
    chk("sf_mis", 32'(mispredict_d_o), 0);
    cyc();
    stall_d_i = 0; flush_d_i = 0; pc_f_i = 32'h0040_0200; #1;
    chk("flush_wins", 32'(mispredict_d_o), 0);
    chk_stats("final", 9, 6);
    cyc();

    // reset during an update
    rst_i = 1; resolve_d_i = 1; taken_d_i = 1; pc_d_i = 32'h0040_0010;
    target_d_i = 32'h0040_0700; pc_f_i = 32'h0040_0110; #1;
    chk("inrst_pt", 32'(pred_taken_f_o), 0);
    chk_stats("inrst", 0, 0);
    cyc();
    rst_i = 0; resolve_d_i = 0; #1;
    chk("postrst_pt", 32'(pred_taken_f_o), 0);
    chk("postrst_mis", 32'(mispredict_d_o), 0);
    cyc();
    pc_f_i = 32'h0040_0010; #1;
    chk("postrst_pt2", 32'(pred_taken_f_o), 0);
    chk_stats("postrst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 64: number of table entries; a power of two, 4..1024.
REQ-002 Parameter CNT_W, default 2: direction counter width, 1..4.
REQ-003 Parameter PC_W, default 32: PC width; IDX_W = log2(ENTRIES), TAG_W = PC_W-IDX_W-2.
REQ-004 Clock is clk_i; reset is rst_i, synchronous, active-high.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 pc_f_i  in  PC_W  fetch-stage PC.
REQ-008 pred_taken_f_o  out  1  predict redirect for pc_f_i.
REQ-009 pred_target_f_o  out  PC_W  predicted target; equals pc_f_i+4 when not taken.
REQ-010 stall_d_i  in  1  hold the F->D prediction register.
REQ-011 flush_d_i  in  1  clear the F->D prediction register.
REQ-012 resolve_d_i  in  1  decode holds a resolved branch/jump.
REQ-013 pc_d_i  in  PC_W  PC of the instruction in decode.
REQ-014 taken_d_i  in  1  actual direction.
REQ-015 target_d_i  in  PC_W  actual target.
REQ-016 mispredict_d_o  out  1  fetch must redirect to redirect_pc_d_o.
REQ-017 redirect_pc_d_o  out  PC_W  correct next PC.
REQ-018 branch_cnt_o  out  32  resolved-branch count.
REQ-019 mispredict_cnt_o  out  32  misprediction count.

Function
REQ-020 Entry fields: valid, tag[TAG_W], target[PC_W], counter[CNT_W]; index = pc[IDX_W+1:2], tag = pc[PC_W-1:IDX_W+2].
REQ-021 Lookup is combinational, zero latency: hit = valid && tag match; pred_taken_f_o = hit && counter MSB; pred_target_f_o = pred_taken_f_o ? stored target : pc_f_i+4, computed modulo 2^PC_W.
REQ-022 An F->D register captures pred_taken and pred_target each cycle; it holds when stall_d_i=1 and clears to 0 when flush_d_i=1; flush_d_i wins when both are high.
REQ-023 update = resolve_d_i && !stall_d_i; a stalled branch updates exactly once, in the cycle it leaves decode.
REQ-024 mispredict_d_o = update && (taken_d_i != pred_taken_d || (taken_d_i && target_d_i != pred_target_d)); it is combinational.
REQ-025 mispredict_d_o also asserts when !resolve_d_i && pred_taken_d && !stall_d_i (a non-branch aliased to taken); in that case redirect_pc_d_o = pc_d_i+4.
REQ-026 Otherwise redirect_pc_d_o = taken_d_i ? target_d_i : pc_d_i+4.
REQ-027 On update with a hit:
  - counter saturating +1 if taken, -1 if not taken (no wrap at all-ones or zero);
  - target overwritten when taken.
REQ-028 On update with a miss and taken: allocate the entry (overwrite, no replacement policy); valid=1, tag and target written, counter = 2^(CNT_W-1) (weakly taken).
REQ-029 On update with a miss and not taken: the table is unchanged.
REQ-030 Table writes take effect at the next clk_i edge; a same-cycle lookup of the same index returns the old contents.

Reset
REQ-031 rst_i clears every valid bit, every counter, the F->D register and both statistics counters within one cycle; a reset asserted mid-stall or mid-update discards that update.
REQ-032 During and immediately after reset: pred_taken_f_o=0, pred_target_f_o=pc_f_i+4, mispredict_d_o=0 unless driven by resolve_d_i inputs, branch_cnt_o=0, mispredict_cnt_o=0.

Configuration
REQ-033 With macro BP_STATS_EN defined, branch_cnt_o increments on each update and mispredict_cnt_o increments on each cycle where mispredict_d_o=1 and stall_d_i=0; both saturate at 0xFFFFFFFF.
REQ-034 Without BP_STATS_EN, the counters are not built and both ports are constant 0.

Verification
REQ-035 Reset, then pc_f_i=0x00400010 -> pred_taken_f_o=0, pred_target_f_o=0x00400014.
REQ-036 Resolve a taken branch at 0x00400010 to 0x00400100 (miss) -> mispredict_d_o=1, redirect 0x00400100; the next lookup of 0x00400010 gives taken, target 0x00400100, counter 2.
REQ-037 Three further taken updates -> counter saturates at 3; then not-taken, not-taken -> counter 1, prediction not-taken, redirect_pc_d_o=0x00400014 on the first.
REQ-038 Hold stall_d_i=1 for 3 cycles with resolve_d_i=1 -> no counter or statistics change until the release cycle, then exactly one update.
REQ-039 With ENTRIES=64, PCs 0x00400010 and 0x00400110 share index 4 and differ in tag -> no hit on the alias; allocating 0x00400110 evicts 0x00400010.
REQ-040 With BP_STATS_EN, 10 updates with 4 mispredicts -> branch_cnt_o=10, mispredict_cnt_o=4; without the macro both read 0.
